fp_norm_round: RTL and testbench

- Sequential normalise-and-round stage for IEEE-754 single precision. It sits directly downstream of the combinational adder datapath.
- It accepts the adder's raw sign, exponent, 25-bit unnormalised mantissa and guard/round/sticky bits over a valid/ready handshake.
- It normalises by shifting one bit per cycle, rounds to nearest-even, and packs a 32-bit result.
- It holds that result in a single output buffer until the consumer accepts it.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_rne_round.sv | 34 +++
 rtl/fp_norm_round.sv | 137 +++++++++++++
 tb/tb_fp_norm_round.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared widths, FSM encoding and IEEE-754 packing helper for the
// single-precision normalise/round stage.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int EXP_MAX = 255;
    localparam int BIAS    = 127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [EXP_W+MAN_W:0] pack(
        input logic             sign,
        input logic [EXP_W-1:0] exp,
        input logic [MAN_W-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even on a 24-bit significand with
// guard/round/sticky; reports inexact and exponent overflow.
module fp_rne_round
    import fp_pkg::*;
(
    input  logic [MAN_W:0]   mant,
    input  logic [2:0]       grs,
    input  logic [EXP_W-1:0] exp,
    output logic [MAN_W:0]   mant_out,
    output logic [EXP_W-1:0] exp_out,
    output logic             inexact,
    output logic             overflow
);

    logic             inc;
    logic [MAN_W+1:0] sum;
    logic [EXP_W:0]   exp_wide;

    always_comb begin
        inc      = grs[2] & (grs[1] | grs[0] | mant[0]);
        sum      = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, inc};
        mant_out = sum[MAN_W:0];
        exp_wide = {1'b0, exp};
        // 1.111..1 + ulp carries out: renormalise to 1.000..0 one binade up
        if (sum[MAN_W+1]) begin
            mant_out = {1'b1, {MAN_W{1'b0}}};
            exp_wide = {1'b0, exp} + {{EXP_W{1'b0}}, 1'b1};
        end
        exp_out  = exp_wide[EXP_W-1:0];
        inexact  = |grs;
        overflow = exp_wide >= (EXP_W + 1)'(EXP_MAX);
    end

endmodule

// File: rtl/fp_norm_round.sv
// Sequential normalise-and-round stage: one-bit-per-cycle left shift,
// RNE rounding, single output buffer held until the consumer accepts.
module fp_norm_round #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int EXP_MAX = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+1:0]       in_mant,
    input  logic [2:0]             in_grs,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_inexact,
    output logic                   out_overflow
);
    import fp_pkg::*;

    state_t           state;
    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic [MAN_W:0]   mant_q;
    logic [2:0]       grs_q;

    logic [MAN_W:0]   r_mant;
    logic [EXP_W-1:0] r_exp;
    logic             r_inexact;
    logic             r_overflow;
    logic [EXP_W-1:0] r_exp_field;
    logic [MAN_W-1:0] r_frac;
    logic [MAN_W-1:0] nan_frac;

    fp_rne_round u_round (
        .mant     (mant_q),
        .grs      (grs_q),
        .exp      (exp_q),
        .mant_out (r_mant),
        .exp_out  (r_exp),
        .inexact  (r_inexact),
        .overflow (r_overflow)
    );

    always_comb begin
        nan_frac = in_mant[MAN_W-1:0];
        if (|in_mant[MAN_W-1:0])
            nan_frac[MAN_W-1] = 1'b1;
        // Denormals carry exp_q==1 but pack a zero field unless rounding
        // pushed the significand into the hidden bit.
        r_exp_field = r_mant[MAN_W] ? r_exp : '0;
        r_frac      = r_mant[MAN_W-1:0];
        if (r_overflow) begin
            r_exp_field = '1;
            r_frac      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            mant_q       <= '0;
            grs_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        sign_q   <= in_sign;
                        mant_q   <= in_mant[MAN_W:0];
                        grs_q    <= in_grs;
                        exp_q    <= in_exp;
                        if (in_exp == EXP_W'(EXP_MAX)) begin
                            out_result   <= pack(in_sign, '1, nan_frac);
                            out_inexact  <= 1'b0;
                            out_overflow <= 1'b0;
                            out_valid    <= 1'b1;
                            state        <= DONE;
                        end else if (in_mant == '0) begin
                            out_result   <= pack(in_sign, '0, '0);
                            out_inexact  <= 1'b0;
                            out_overflow <= 1'b0;
                            out_valid    <= 1'b1;
                            state        <= DONE;
                        end else if (in_mant[MAN_W+1]) begin
                            mant_q <= in_mant[MAN_W+1:1];
                            grs_q  <= {in_mant[0], in_grs[2], |in_grs[1:0]};
                            exp_q  <= in_exp + EXP_W'(1);
                            state  <= ROUND;
                        end else if (in_mant[MAN_W] || in_exp <= EXP_W'(1)) begin
                            // exp 0 and 1 share the denormal scale
                            if (in_exp == '0)
                                exp_q <= EXP_W'(1);
                            state <= ROUND;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    mant_q <= {mant_q[MAN_W-1:0], grs_q[2]};
                    grs_q  <= {grs_q[1], 1'b0, grs_q[0]};
                    exp_q  <= exp_q - EXP_W'(1);
                    // look ahead so the last shift and the exit share a cycle
                    if (mant_q[MAN_W-1] || exp_q == EXP_W'(2))
                        state <= ROUND;
                end
                ROUND: begin
                    out_result   <= pack(sign_q, r_exp_field, r_frac);
                    out_inexact  <= r_inexact;
                    out_overflow <= r_overflow;
                    out_valid    <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed-vector bench for fp_norm_round: results, flags, latency,
// backpressure and mid-operation reset.
module tb_fp_norm_round;
    import fp_pkg::*;

    localparam logic [7:0] B = 8'(BIAS);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic [2:0]  in_grs = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_inexact;
    logic        out_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_norm_round dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .in_grs       (in_grs),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow)
    );

    task automatic send(input logic sg, input logic [7:0] e, input logic [24:0] m, input logic [2:0] g);
        @(negedge clk);
        in_sign = sg; in_exp = e; in_mant = m; in_grs = g; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // latency counts the capture cycle as 1
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_valid timeout got out_valid=%b want 1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", out_result); end
        n_cmp++; if ({out_inexact, out_overflow} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {out_inexact, out_overflow}); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_normal();
        int lat;
        send(1'b0, B, 25'h0C00000, 3'b000);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL normal_in_ready got %b want 0", in_ready); end
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h3FC00000) begin n_bad++; $display("FAIL normal_result got %h want 3fc00000", out_result); end
        n_cmp++; if ({out_inexact, out_overflow} !== 2'b00) begin n_bad++; $display("FAIL normal_flags got %b want 00", {out_inexact, out_overflow}); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL normal_latency got %0d want 2", lat); end
        @(posedge clk); #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL normal_handshake got v/r=%b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_carry();
        int lat;
        send(1'b0, B, 25'h1000000, 3'b000);
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h40000000) begin n_bad++; $display("FAIL carry_result got %h want 40000000", out_result); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL carry_latency got %0d want 2", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_shift();
        int lat;
        send(1'b0, B, 25'h0200000, 3'b000);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL shift_in_ready got %b want 0", in_ready); end
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h3E800000) begin n_bad++; $display("FAIL shift_result got %h want 3e800000", out_result); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL shift_latency got %0d want 4", lat); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL shift_in_ready_done got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL shift_in_ready_after got %b want 1", in_ready); end
    endtask

    task automatic test_round_even();
        int lat;
        send(1'b0, B, 25'h0FFFFFF, 3'b100);
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h40000000) begin n_bad++; $display("FAIL tie_up_result got %h want 40000000", out_result); end
        n_cmp++; if ({out_inexact, out_overflow} !== 2'b10) begin n_bad++; $display("FAIL tie_up_flags got %b want 10", {out_inexact, out_overflow}); end
        @(posedge clk); #1;
        send(1'b0, B, 25'h0FFFFFE, 3'b100);
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h3FFFFFFE) begin n_bad++; $display("FAIL tie_down_result got %h want 3ffffffe", out_result); end
        n_cmp++; if (out_inexact !== 1'b1) begin n_bad++; $display("FAIL tie_down_inexact got %b want 1", out_inexact); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow_zero();
        int lat;
        send(1'b0, 8'hFE, 25'h1000000, 3'b000);
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h7F800000) begin n_bad++; $display("FAIL ovf_result got %h want 7f800000", out_result); end
        n_cmp++; if (out_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", out_overflow); end
        @(posedge clk); #1;
        send(1'b1, 8'h40, 25'h0000000, 3'b000);
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h80000000) begin n_bad++; $display("FAIL zero_result got %h want 80000000", out_result); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL zero_latency got %0d want 1", lat); end
        n_cmp++; if (out_overflow !== 1'b0) begin n_bad++; $display("FAIL zero_ovf got %b want 0", out_overflow); end
        @(posedge clk); #1;
    endtask

    task automatic test_special_denorm();
        int lat;
        send(1'b0, 8'hFF, 25'h0800001, 3'b000);
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h7FC00001) begin n_bad++; $display("FAIL qnan_result got %h want 7fc00001", out_result); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL qnan_latency got %0d want 1", lat); end
        @(posedge clk); #1;
        send(1'b0, 8'h03, 25'h0000001, 3'b000);
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h00000004) begin n_bad++; $display("FAIL denorm_result got %h want 00000004", out_result); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL denorm_latency got %0d want 4", lat); end
        @(posedge clk); #1;
        send(1'b0, 8'h01, 25'h07FFFFF, 3'b110);
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h00800000) begin n_bad++; $display("FAIL denorm_up_result got %h want 00800000", out_result); end
        n_cmp++; if (out_inexact !== 1'b1) begin n_bad++; $display("FAIL denorm_up_inexact got %b want 1", out_inexact); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(1'b0, B, 25'h0C00000, 3'b000);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_exp = 8'h10; in_mant = 25'h1000000;
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
            n_cmp++; if (out_result !== 32'h3FC00000) begin n_bad++; $display("FAIL bp_result[%0d] got %h want 3fc00000", i, out_result); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_release got v/r=%b want 01", {out_valid, in_ready}); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_stray got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        send(1'b0, B, 25'h0000001, 3'b000);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        @(negedge clk) rst = 1'b0;
        send(1'b0, B, 25'h0C00000, 3'b000);
        wait_valid(lat);
        n_cmp++; if (out_result !== 32'h3FC00000) begin n_bad++; $display("FAIL rst_fresh_result got %h want 3fc00000", out_result); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rst_fresh_latency got %0d want 2", lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_carry();
        test_shift();
        test_round_even();
        test_overflow_zero();
        test_special_denorm();
        test_backpressure();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
